// File: rtl/ram_unit_pkg.sv
// ram_unit_pkg: shared sizing defaults and the program-loader state encoding
// used by ram_unit and its loader sub-module.
package ram_unit_pkg;

   localparam int DEF_DATA_W = 8;   // word width
   localparam int DEF_ADDR_W = 4;   // address width, depth = 2**ADDR_W

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_LOAD = 2'd1,
      ST_DONE = 2'd2
   } ld_state_t;

endpackage

// File: rtl/ram_unit_loader.sv
// ram_loader: program-load FSM. Streams bytes into consecutive locations
// starting at 0, keeps a running mod-2**DATA_W sum and flags completion.
// Ports:
//   clk, clr            clock, synchronous active-high reset
//   prog_mode           request load mode (drop to abort / leave DONE)
//   prog_data/valid     byte offered by the external loader
//   prog_ready          high in LOAD: a valid byte is taken this cycle
//   prog_addr/sum/done  next write location, running sum, all loaded
//   ld_we               write strobe for the storage port (data = prog_data,
//                       address = prog_addr)
//   bus_idle            FSM in IDLE (bus access allowed when prog_mode=0)
module ram_loader
   import ram_unit_pkg::*;
#(
   parameter int DATA_W = DEF_DATA_W,
   parameter int ADDR_W = DEF_ADDR_W
) (
   input  logic              clk,
   input  logic              clr,
   input  logic              prog_mode,
   input  logic [DATA_W-1:0] prog_data,
   input  logic              prog_valid,
   output logic              prog_ready,
   output logic [ADDR_W-1:0] prog_addr,
   output logic [DATA_W-1:0] prog_sum,
   output logic              prog_done,
   output logic              ld_we,
   output logic              bus_idle
);

   localparam logic [ADDR_W-1:0] LAST = {ADDR_W{1'b1}};

   ld_state_t         state_q, state_n;
   logic [ADDR_W-1:0] addr_n;
   logic [DATA_W-1:0] sum_n;
   logic              accept;

   assign prog_ready = (state_q == ST_LOAD);
   assign prog_done  = (state_q == ST_DONE);
   assign bus_idle   = (state_q == ST_IDLE);
   assign accept     = prog_ready && prog_valid;
   assign ld_we      = accept;

   always_ff @(posedge clk) begin
      if (clr) begin
         state_q   <= ST_IDLE;
         prog_addr <= '0;
         prog_sum  <= '0;
      end else begin
         state_q   <= state_n;
         prog_addr <= addr_n;
         prog_sum  <= sum_n;
      end
   end

   always_comb begin
      state_n = state_q;
      addr_n  = prog_addr;
      sum_n   = prog_sum;
      case (state_q)
         ST_IDLE: begin
            if (prog_mode) begin
               state_n = ST_LOAD;
               addr_n  = '0;
               sum_n   = '0;
            end
         end
         ST_LOAD: begin
            // A byte offered on the abort cycle is still taken because
            // ready is high; the abort only decides the next state.
            if (accept) begin
               addr_n = prog_addr + 1'b1;   // wraps to 0 after LAST
               sum_n  = prog_sum + prog_data;
            end
            if (!prog_mode)
               state_n = ST_IDLE;
            else if (accept && prog_addr == LAST)
               state_n = ST_DONE;
         end
         ST_DONE: begin
            if (!prog_mode)
               state_n = ST_IDLE;
         end
         default: state_n = ST_IDLE;
      endcase
   end

endmodule

// File: rtl/ram_unit.sv
// ram_unit: 2**ADDR_W x DATA_W register file with a bus read/write port and
// a sequential program loader that owns the write port while loading.
// Ports:
//   clk, clr            clock, synchronous active-high reset (clears memory)
//   addr, busin, wr, rd bus port; busout is combinational, 0 when not driving
//   prog_*              loader interface, see ram_loader
module ram_unit
   import ram_unit_pkg::*;
#(
   parameter int DATA_W = DEF_DATA_W,
   parameter int ADDR_W = DEF_ADDR_W
) (
   input  logic              clk,
   input  logic              clr,
   input  logic [ADDR_W-1:0] addr,
   input  logic [DATA_W-1:0] busin,
   input  logic              wr,
   input  logic              rd,
   output logic [DATA_W-1:0] busout,
   input  logic              prog_mode,
   input  logic [DATA_W-1:0] prog_data,
   input  logic              prog_valid,
   output logic              prog_ready,
   output logic [ADDR_W-1:0] prog_addr,
   output logic [DATA_W-1:0] prog_sum,
   output logic              prog_done
);

   localparam int DEPTH = 1 << ADDR_W;

   logic [DEPTH-1:0][DATA_W-1:0] mem;
   logic ld_we, bus_idle, bus_en;

   ram_loader #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_loader (
      .clk        (clk),
      .clr        (clr),
      .prog_mode  (prog_mode),
      .prog_data  (prog_data),
      .prog_valid (prog_valid),
      .prog_ready (prog_ready),
      .prog_addr  (prog_addr),
      .prog_sum   (prog_sum),
      .prog_done  (prog_done),
      .ld_we      (ld_we),
      .bus_idle   (bus_idle)
   );

   // Bus access only in IDLE with no load requested, so the loader never
   // competes with the bus for the single write port.
   assign bus_en = bus_idle && !prog_mode;

   always_ff @(posedge clk) begin
      if (clr)
         mem <= '0;
      else if (ld_we)
         mem[prog_addr] <= prog_data;
      else if (wr && bus_en)
         mem[addr] <= busin;
   end

   assign busout = (rd && bus_en) ? mem[addr] : '0;

endmodule

// File: tb/tb_ram_unit.sv
module tb_ram_unit;

   logic       clk = 1'b0;
   logic       clr, wr, rd, prog_mode, prog_valid;
   logic [3:0] addr;
   logic [7:0] busin, prog_data;
   logic [7:0] busout, prog_sum;
   logic [3:0] prog_addr;
   logic       prog_ready, prog_done;

   int total = 0;
   int bad   = 0;

   // reference model: memory image plus loader status
   int  m_mem [16];
   bit  m_loading, m_done;
   int  m_paddr, m_sum;

   always #5 clk = ~clk;

   ram_unit dut (
      .clk(clk), .clr(clr), .addr(addr), .busin(busin), .wr(wr), .rd(rd),
      .busout(busout), .prog_mode(prog_mode), .prog_data(prog_data),
      .prog_valid(prog_valid), .prog_ready(prog_ready), .prog_addr(prog_addr),
      .prog_sum(prog_sum), .prog_done(prog_done)
   );

   task automatic chk(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic int exp_bus();
      if (rd && !m_loading && !m_done && !prog_mode) return m_mem[addr];
      return 0;
   endfunction

   task automatic model_edge();
      bit last;
      if (clr) begin
         foreach (m_mem[i]) m_mem[i] = 0;
         m_loading = 0; m_done = 0; m_paddr = 0; m_sum = 0;
      end else if (m_loading) begin
         last = 0;
         if (prog_valid) begin
            m_mem[m_paddr] = prog_data;
            m_sum = (m_sum + prog_data) % 256;
            last = (m_paddr == 15);
            m_paddr = (m_paddr + 1) % 16;
         end
         if (!prog_mode) m_loading = 0;
         else if (last) begin m_loading = 0; m_done = 1; end
      end else if (m_done) begin
         if (!prog_mode) m_done = 0;
      end else begin
         if (prog_mode) begin
            m_loading = 1; m_paddr = 0; m_sum = 0;
         end else if (wr) m_mem[addr] = busin;
      end
   endtask

   task automatic model_check();
      chk("ready", prog_ready, m_loading);
      chk("done",  prog_done,  m_done);
      chk("paddr", prog_addr,  m_paddr);
      chk("psum",  prog_sum,   m_sum);
      chk("busout", busout,    exp_bus());
   endtask

   task automatic cycle();
      @(posedge clk);
      model_edge();
      #1;
      model_check();
   endtask

   task automatic idle_in();
      clr = 0; wr = 0; rd = 0; addr = 0; busin = 0;
      prog_mode = 0; prog_data = 0; prog_valid = 0;
   endtask

   task automatic do_clr();
      idle_in(); clr = 1; cycle(); clr = 0;
   endtask

   task automatic rd_chk(input string name, input int a, input int exp);
      wr = 0; rd = 1; addr = 4'(a);
      #1;
      chk(name, busout, exp);
      rd = 0;
   endtask

   typedef struct {
      bit       clr, wr, rd, pm;
      bit [3:0] addr;
      bit [7:0] busin;
      bit [7:0] e_bus;
      bit       e_rdy;
   } vec_t;

   vec_t vt [7];

   initial begin
      idle_in();
      vt[0] = '{clr:1, wr:0, rd:0, pm:0, addr:4'h0, busin:8'h00, e_bus:8'h00, e_rdy:0};
      vt[1] = '{clr:0, wr:1, rd:0, pm:0, addr:4'ha, busin:8'h3c, e_bus:8'h00, e_rdy:0};
      vt[2] = '{clr:0, wr:0, rd:1, pm:0, addr:4'ha, busin:8'h00, e_bus:8'h3c, e_rdy:0};
      vt[3] = '{clr:0, wr:0, rd:1, pm:0, addr:4'h7, busin:8'h00, e_bus:8'h00, e_rdy:0};
      vt[4] = '{clr:0, wr:1, rd:1, pm:0, addr:4'h7, busin:8'h5a, e_bus:8'h5a, e_rdy:0};
      vt[5] = '{clr:0, wr:0, rd:1, pm:1, addr:4'ha, busin:8'h00, e_bus:8'h00, e_rdy:1};
      vt[6] = '{clr:0, wr:0, rd:1, pm:0, addr:4'ha, busin:8'h00, e_bus:8'h3c, e_rdy:0};

      // table: reset, bus write/read, read-during-write, lockout, abort
      for (int i = 0; i < 7; i++) begin
         clr = vt[i].clr; wr = vt[i].wr; rd = vt[i].rd; prog_mode = vt[i].pm;
         addr = vt[i].addr; busin = vt[i].busin;
         cycle();
         chk($sformatf("vec%0d_bus", i), busout, vt[i].e_bus);
         chk($sformatf("vec%0d_rdy", i), prog_ready, vt[i].e_rdy);
         if (i == 0) begin
            chk("rst_done", prog_done, 0);
            chk("rst_paddr", prog_addr, 0);
            chk("rst_psum", prog_sum, 0);
         end
      end

      // old data before the edge, new data after, same address
      idle_in(); wr = 1; rd = 1; addr = 4'h7; busin = 8'hc3;
      #1 chk("rdw_old", busout, 8'h5a);
      cycle();
      chk("rdw_new", busout, 8'hc3);

      // full load 01..10
      do_clr();
      prog_mode = 1; cycle();
      for (int i = 0; i < 16; i++) begin
         prog_valid = 1; prog_data = 8'(i + 1);
         #1 chk($sformatf("full_rdy%0d", i), prog_ready, 1);
         cycle();
      end
      chk("full_done", prog_done, 1);
      chk("full_sum", prog_sum, 8'h88);
      chk("full_addr", prog_addr, 0);
      prog_valid = 0; prog_mode = 0; cycle();
      chk("full_idle", prog_done, 0);
      chk("full_sum_hold", prog_sum, 8'h88);
      rd_chk("full_rd_f", 15, 8'h10);
      rd_chk("full_rd_0", 0, 8'h01);

      // stall: valid 1,0,0,1
      do_clr();
      prog_mode = 1; cycle();
      begin
         bit [3:0] pat = 4'b1001;
         int       exp_a [4] = '{1, 1, 1, 2};
         for (int k = 0; k < 4; k++) begin
            prog_valid = pat[3 - k]; prog_data = 8'(8'ha0 + k);
            cycle();
            chk($sformatf("stall_addr%0d", k), prog_addr, exp_a[k]);
         end
      end
      prog_valid = 0; prog_mode = 0; cycle();
      rd_chk("stall_m0", 0, 8'ha0);
      rd_chk("stall_m1", 1, 8'ha3);
      rd_chk("stall_m2", 2, 8'h00);

      // abort after 5 bytes over a pre-filled memory
      do_clr();
      for (int i = 0; i < 16; i++) begin
         wr = 1; addr = 4'(i); busin = 8'(8'he0 + i); cycle();
      end
      idle_in(); prog_mode = 1; cycle();
      for (int i = 0; i < 5; i++) begin
         prog_valid = 1; prog_data = 8'(8'h11 + i); cycle();
      end
      prog_valid = 0; prog_mode = 0; cycle();
      chk("abort_done", prog_done, 0);
      chk("abort_rdy", prog_ready, 0);
      for (int i = 0; i < 16; i++)
         rd_chk($sformatf("abort_m%0d", i), i, (i < 5) ? 8'h11 + i : 8'he0 + i);

      // bus lockout during LOAD
      do_clr();
      prog_mode = 1; cycle();
      for (int i = 0; i < 3; i++) begin
         wr = 1; rd = 1; addr = 4'h2; busin = 8'hff;
         prog_valid = 1; prog_data = 8'(8'h40 + i);
         #1 chk($sformatf("lock_bus%0d", i), busout, 0);
         cycle();
      end
      idle_in(); cycle();
      rd_chk("lock_m2", 2, 8'h42);

      // reset on the 8th byte
      do_clr();
      prog_mode = 1; cycle();
      for (int i = 0; i < 8; i++) begin
         prog_valid = 1; prog_data = 8'(8'h71 + i);
         if (i == 7) clr = 1;
         cycle();
      end
      chk("rst_mid_rdy", prog_ready, 0);
      chk("rst_mid_done", prog_done, 0);
      chk("rst_mid_addr", prog_addr, 0);
      chk("rst_mid_sum", prog_sum, 0);
      chk("rst_mid_bus", busout, 0);
      idle_in(); cycle();
      for (int i = 0; i < 16; i++)
         rd_chk($sformatf("rst_mid_m%0d", i), i, 0);

      // randomized traffic against the model
      for (int n = 0; n < 1500; n++) begin
         clr        = ($urandom_range(99) == 0);
         wr         = $urandom_range(1);
         rd         = $urandom_range(1);
         addr       = 4'($urandom);
         busin      = 8'($urandom);
         prog_mode  = ($urandom_range(9) < ((n / 150) % 2 ? 8 : 2));
         prog_valid = ($urandom_range(3) != 0);
         prog_data  = 8'($urandom);
         #1 chk("rnd_bus_pre", busout, exp_bus());
         cycle();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/ram_unit.md
RAM_UNIT -- requirements
Module: ram_unit

Interface
REQ-001 The block SHALL have parameter DATA_W, default 8, meaning word width.
REQ-002 The block SHALL have parameter ADDR_W, default 4, meaning address width; depth is 2**ADDR_W (16).
REQ-003 The block SHALL have port clk, input, 1 bit: single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port clr, input, 1 bit: reset, synchronous and active-high.
REQ-005 The block SHALL have port addr, input, ADDR_W bits: location selected by the memory address register output.
REQ-006 The block SHALL have port busin, input, DATA_W bits: write data from the bus.
REQ-007 The block SHALL have port wr, input, 1 bit: write busin into mem[addr].
REQ-008 The block SHALL have port rd, input, 1 bit: drive mem[addr] onto busout.
REQ-009 The block SHALL have port busout, output, DATA_W bits: read data; 0 when not driving.
REQ-010 The block SHALL have port prog_mode, input, 1 bit: selects program-load mode.
REQ-011 The block SHALL have port prog_data, input, DATA_W bits: loader byte.
REQ-012 The block SHALL have port prog_valid, input, 1 bit: prog_data valid.
REQ-013 The block SHALL have port prog_ready, output, 1 bit: loader accepts a byte this cycle.
REQ-014 The block SHALL have port prog_addr, output, ADDR_W bits: next location the loader writes.
REQ-015 The block SHALL have port prog_sum, output, DATA_W bits: mod-256 sum of accepted loader bytes.
REQ-016 The block SHALL have port prog_done, output, 1 bit: all 16 locations loaded.

Function
REQ-017 Storage SHALL be 16 x DATA_W registers.
REQ-018 Bus write: when wr=1, state IDLE and prog_mode=0, mem[addr] SHALL be written with busin at the edge.
REQ-019 busout SHALL be combinational: mem[addr] when rd=1, state IDLE and prog_mode=0; otherwise 8'h00.
REQ-020 With wr=rd=1 on the same address, busout SHALL show the old contents until the edge and the new contents after it.
REQ-021 The loader FSM SHALL have states IDLE, LOAD and DONE.
REQ-022 IDLE -> LOAD SHALL occur when prog_mode=1; prog_addr SHALL clear to 0 and prog_sum to 0 on entry.
REQ-023 In LOAD, prog_ready SHALL be 1; in IDLE and DONE it SHALL be 0.
REQ-024 A byte is accepted when prog_valid and prog_ready are both 1; on acceptance mem[prog_addr] <= prog_data, prog_addr increments and prog_sum += prog_data (wraps mod 256).
REQ-025 Acceptance at prog_addr=15 SHALL move the FSM to DONE; prog_addr SHALL wrap to 0.
REQ-026 In DONE, prog_done SHALL be 1, and the FSM SHALL return to IDLE when prog_mode=0; prog_sum SHALL hold until the next LOAD entry.
REQ-027 prog_mode=0 while in LOAD SHALL abort to IDLE next edge; locations already written SHALL keep their data and prog_done SHALL stay 0.
REQ-028 prog_valid=0 in LOAD SHALL stall with no state change.
REQ-029 wr and rd SHALL be ignored whenever state is not IDLE or prog_mode=1.

Reset
REQ-030 clr=1 at an edge SHALL clear all 16 locations to 0, set state IDLE, prog_addr 0, prog_sum 0, prog_ready 0 and prog_done 0; busout therefore reads 0.
REQ-031 clr SHALL override wr and loader acceptance in the same cycle, including mid-LOAD.

Structure
REQ-032 DATA_W, ADDR_W and the loader state encoding (IDLE=0, LOAD=1, DONE=2) SHALL live in a shared package.
REQ-033 The loader FSM, counter and sum SHALL be a sub-module ram_loader, whose outputs feed the storage write port of ram_unit.

Verification
REQ-034 The bench SHALL cover bus write then read: clr pulse; wr=1, addr=4'ha, busin=8'h3c; next cycle rd=1 -> busout=8'h3c; addr=4'h7 -> busout=8'h00.
REQ-035 The bench SHALL cover a full load: prog_mode=1; 16 bytes 8'h01..8'h10 streamed with prog_valid held high -> prog_ready high for 16 cycles, prog_done=1 with prog_sum=8'h88; then prog_mode=0, rd at addr=4'hf -> 8'h10.
REQ-036 The bench SHALL cover a stall: prog_valid toggled 1,0,0,1 -> prog_addr advances only on valid cycles and memory shows no skipped locations.
REQ-037 The bench SHALL cover an abort: prog_mode dropped after 5 bytes -> IDLE with prog_done=0; mem[0..4] loaded and mem[5..15] unchanged.
REQ-038 The bench SHALL cover bus lockout: wr=1 to addr=4'h2 during LOAD -> mem[2] written only by the loader byte; rd=1 during LOAD -> busout=8'h00.
REQ-039 The bench SHALL cover reset mid-load: clr at the 8th byte -> all outputs 0 next cycle, all locations read 8'h00.
